servo_pwm: RTL and testbench

Multi-channel hobby-servo pulse generator for the arm controller, directly downstream of `read_number`. It consumes each assembled 32-bit command word plus a one-cycle valid strobe and decodes a channel index and pulse width. It drives one 50 Hz-class PWM output per joint. Widths are double-buffered so a command never changes a pulse that is already in flight.

---
 rtl/servo_pwm.sv | 171 +++++++++++++++++
 tb/tb_servo_pwm.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm.sv
// servo_pwm: multi-channel hobby-servo pulse generator.
//
// A free-running prescaler divides the system clock down to a 1 us tick,
// and a microsecond counter walks through one PWM frame. Each channel owns
// a pending width, written by commands at any time, and an active width,
// which the pulse compare uses. Active loads from pending only at a frame
// boundary, so a command never disturbs a pulse already in flight.
//
// Command interface: word_valid is a one-cycle strobe with no ready
// signal; word is sampled on every cycle word_valid is high and every
// strobe is accepted, so back-to-back commands on consecutive cycles are
// fine. Word layout: [3:0] channel, [15:4] ignored, [31:16] width in us.

module servo_pwm #(
    parameter int CLKS_PER_US = 12,
    parameter int PERIOD_US   = 20000,
    parameter int NUM_SERVOS  = 4,
    parameter int MIN_US      = 500,
    parameter int MAX_US      = 2500,
    parameter int CENTER_US   = 1500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           word,
    input  logic                  word_valid,
    output logic [NUM_SERVOS-1:0] pwm,
    output logic                  frame_start,
    output logic                  cmd_error,
    output logic                  cmd_clamped
);

    localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLKS_PER_US - 1);
    localparam logic [15:0]      FRAME_LAST = 16'(PERIOD_US - 1);
    localparam logic [15:0]      MIN_W      = 16'(MIN_US);
    localparam logic [15:0]      MAX_W      = 16'(MAX_US);
    localparam logic [15:0]      CENTER_W   = 16'(CENTER_US);
    localparam logic [4:0]       NUM_CH     = 5'(NUM_SERVOS);

    // Timebase state
    logic [PRE_W-1:0] pre;
    logic [15:0]      frame_us;
    logic [15:0]      frame_us_next;
    logic             us_tick;
    logic             boundary;

    // Command decode
    logic [3:0]  cmd_ch;
    logic [15:0] cmd_width;
    logic [15:0] cmd_width_clamped;
    logic        cmd_ch_ok;
    logic        cmd_out_of_range;
    logic        unused_word_bits;

    // Per-channel width registers
    logic [15:0] pending     [NUM_SERVOS];
    logic [15:0] active      [NUM_SERVOS];
    logic [15:0] active_next [NUM_SERVOS];

    // Bits 15:4 carry no meaning; fold them so they are visibly consumed.
    assign unused_word_bits = ^word[15:4];

    // Tick and frame-boundary detection, plus the counter value after this edge.
    always_comb begin
        us_tick       = (pre == PRE_LAST);
        boundary      = us_tick && (frame_us == FRAME_LAST);
        frame_us_next = frame_us;
        if (boundary) begin
            frame_us_next = 16'd0;
        end else if (us_tick) begin
            frame_us_next = frame_us + 16'd1;
        end
    end

    // Split the command word and clamp the requested width into range.
    always_comb begin
        cmd_ch            = word[3:0];
        cmd_width         = word[31:16];
        cmd_ch_ok         = ({1'b0, cmd_ch} < NUM_CH);
        cmd_out_of_range  = (cmd_width < MIN_W) || (cmd_width > MAX_W);
        cmd_width_clamped = cmd_width;
        if (cmd_width < MIN_W) begin
            cmd_width_clamped = MIN_W;
        end else if (cmd_width > MAX_W) begin
            cmd_width_clamped = MAX_W;
        end
    end

    // Active widths as they will be after this edge; the pulse register
    // compares against these so it lines up with the new frame position.
    always_comb begin
        for (int i = 0; i < NUM_SERVOS; i++) begin
            active_next[i] = boundary ? pending[i] : active[i];
        end
    end

    // Prescaler: counts clocks within one microsecond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (us_tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Microsecond position within the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_us <= 16'd0;
        end else begin
            frame_us <= frame_us_next;
        end
    end

    // Pending widths: the last accepted command for a channel wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                pending[i] <= CENTER_W;
            end
        end else if (word_valid && cmd_ch_ok) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                if (cmd_ch == 4'(i)) begin
                    pending[i] <= cmd_width_clamped;
                end
            end
        end
    end

    // Active widths: reload from pending only at the frame boundary, so a
    // command landing on the boundary edge is seen one frame later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                active[i] <= CENTER_W;
            end
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                active[i] <= active_next[i];
            end
        end
    end

    // Pulse outputs: high while the frame position is below the active width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                pwm[i] <= (frame_us_next < active_next[i]);
            end
        end
    end

    // Status strobes: frame start marker and one-cycle command outcome flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            cmd_error   <= 1'b0;
            cmd_clamped <= 1'b0;
        end else begin
            frame_start <= boundary;
            cmd_error   <= word_valid && !cmd_ch_ok;
            cmd_clamped <= word_valid && cmd_ch_ok && cmd_out_of_range;
        end
    end

endmodule

// File: tb/tb_servo_pwm.sv
// tb_servo_pwm: directed stimulus for servo_pwm with a time-based model.
// The model derives every output from the number of clock edges since
// reset release; pulse widths per frame are also measured and pinned to
// hand-computed literals.

module tb_servo_pwm;

  localparam int CLKS   = 2;
  localparam int PERIOD = 2600;
  localparam int NS     = 4;
  localparam int MINU   = 500;
  localparam int MAXU   = 2500;
  localparam int CENTER = 1500;
  localparam int FRAME  = CLKS * PERIOD;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   word = 32'hFFFF_FFFF;
  logic          word_valid = 1'b0;
  logic [NS-1:0] pwm;
  logic          frame_start;
  logic          cmd_error;
  logic          cmd_clamped;

  always #5 clk = ~clk;

  servo_pwm #(
    .CLKS_PER_US(CLKS),
    .PERIOD_US  (PERIOD),
    .NUM_SERVOS (NS),
    .MIN_US     (MINU),
    .MAX_US     (MAXU),
    .CENTER_US  (CENTER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .word       (word),
    .word_valid (word_valid),
    .pwm        (pwm),
    .frame_start(frame_start),
    .cmd_error  (cmd_error),
    .cmd_clamped(cmd_clamped)
  );

  // ---------------- bookkeeping ----------------
  int pass_n  = 0;
  int total_n = 0;
  int fail_n  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) begin
      pass_n++;
    end else begin
      fail_n++;
      if (fail_n <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // k = clock edges since reset release. Frame position after edge k is
  // (k / CLKS) mod PERIOD; a new frame starts on every edge that is a
  // multiple of FRAME clocks.
  int            k = 0;
  int            m_pend [NS];
  int            m_act  [NS];
  logic [NS-1:0] e_pwm   = '0;
  logic          e_fs    = 1'b0;
  logic          e_err   = 1'b0;
  logic          e_clamp = 1'b0;

  initial begin
    int ch;
    int wd;
    int fus;
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = CENTER;
      m_act[i]  = CENTER;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        k = 0;
        for (int i = 0; i < NS; i++) begin
          m_pend[i] = CENTER;
          m_act[i]  = CENTER;
        end
        e_pwm = '0; e_fs = 1'b0; e_err = 1'b0; e_clamp = 1'b0;
      end else begin
        k = k + 1;
        e_fs = ((k % FRAME) == 0);
        if (e_fs) begin
          for (int i = 0; i < NS; i++) m_act[i] = m_pend[i];
        end
        e_err = 1'b0;
        e_clamp = 1'b0;
        if (word_valid) begin
          ch = int'(word[3:0]);
          wd = int'(word[31:16]);
          if (ch >= NS) begin
            e_err = 1'b1;
          end else if (wd < MINU) begin
            m_pend[ch] = MINU; e_clamp = 1'b1;
          end else if (wd > MAXU) begin
            m_pend[ch] = MAXU; e_clamp = 1'b1;
          end else begin
            m_pend[ch] = wd;
          end
        end
        fus = (k / CLKS) % PERIOD;
        for (int i = 0; i < NS; i++) e_pwm[i] = (fus < m_act[i]);
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("pwm", pwm, e_pwm);
        check("frame_start", frame_start, e_fs);
        check("cmd_error", cmd_error, e_err);
        check("cmd_clamped", cmd_clamped, e_clamp);
      end
    end
  end

  // ---------------- width / period collector ----------------
  // Frame 0 is the partial interval after reset; frame f >= 1 begins at
  // the f-th frame_start. w[f][ch] = clocks pwm[ch] was high in frame f.
  int cnt [NS];
  int pcnt    = 0;
  int fidx    = 0;
  int w [16][NS];
  int per [16];
  int err_n   = 0;
  int clamp_n = 0;

  initial begin
    for (int i = 0; i < NS; i++) cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fidx = 0;
        pcnt = 0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
      end else begin
        err_n   += int'(cmd_error);
        clamp_n += int'(cmd_clamped);
        if (frame_start) begin
          if (fidx < 16) begin
            for (int i = 0; i < NS; i++) w[fidx][i] = cnt[i];
            per[fidx] = pcnt;
          end
          for (int i = 0; i < NS; i++) cnt[i] = int'(pwm[i]);
          pcnt = 1;
          fidx++;
        end else begin
          for (int i = 0; i < NS; i++) cnt[i] += int'(pwm[i]);
          pcnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] cmd);
    @(negedge clk);
    word = cmd;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    word = 32'hFFFF_FFFF;
  endtask

  task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    word = a;
    word_valid = 1'b1;
    @(negedge clk);
    word = b;
    @(negedge clk);
    word_valid = 1'b0;
    word = 32'hFFFF_FFFF;
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until frame n-1 has been fully measured.
  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (fidx < n && t < 3 * FRAME) begin
      @(posedge clk);
      t++;
    end
    check("reach_frame", longint'(fidx >= n), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    #1 rst = 1'b1;
    skip(3);
    check("rst_pwm", pwm, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_cmd_clamped", cmd_clamped, 0);
    rst = 1'b0;

    // Idle frames: partial first frame loses the reset-release cycle.
    wait_frames(2);
    check("partial_w_ch1", w[0][1], 2999);
    for (int i = 0; i < NS; i++) check("idle_w", w[1][i], 3000);
    check("frame_period", per[1], 5200);

    // ch1 -> 2000 us mid-frame 2.
    skip(1000);
    send(32'h07D0_0001);
    wait_frames(3);
    check("ch1_same_frame", w[2][1], 3000);
    check("ch1_err_n", err_n, 0);
    check("ch1_clamp_n", clamp_n, 0);

    // ch2 -> 100 us, ch3 -> 4000 us, back to back, mid-frame 3.
    skip(500);
    send_pair(32'h0064_0002, 32'h0FA0_0003);
    wait_frames(4);
    check("ch1_next_frame", w[3][1], 4000);
    check("ch2_same_frame", w[3][2], 3000);
    check("ch3_same_frame", w[3][3], 3000);
    check("clamp_n", clamp_n, 2);
    check("clamp_err_n", err_n, 0);

    // Nonexistent channel 9 mid-frame 4.
    skip(500);
    send(32'h05DC_0009);
    wait_frames(5);
    check("ch2_clamped_w", w[4][2], 1000);
    check("ch3_clamped_w", w[4][3], 5000);
    check("err_n", err_n, 1);
    check("err_clamp_n", clamp_n, 2);

    // ch0 -> 1000 us exactly on the edge that starts frame 6.
    t = 0;
    while (k != 6 * FRAME - 1 && t < 3 * FRAME) begin
      @(negedge clk);
      t++;
    end
    check("boundary_align", k, 6 * FRAME - 1);
    word = 32'h03E8_0000;
    word_valid = 1'b1;
    @(negedge clk);
    word_valid = 1'b0;
    word = 32'hFFFF_FFFF;

    wait_frames(7);
    check("err_nochange_ch0", w[5][0], 3000);
    check("err_nochange_ch1", w[5][1], 4000);
    check("err_nochange_ch2", w[5][2], 1000);
    check("err_nochange_ch3", w[5][3], 5000);
    check("boundary_next_ch0", w[6][0], 3000);
    wait_frames(8);
    check("boundary_later_ch0", w[7][0], 2000);

    // Asynchronous reset in the middle of ch1's 2000 us pulse.
    skip(2500);
    check("pwm1_before_rst", pwm[1], 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_frame_start", frame_start, 0);
    skip(2);
    rst = 1'b0;
    wait_frames(1);
    check("post_rst_partial_ch1", w[0][1], 2999);
    wait_frames(2);
    check("post_rst_ch1", w[1][1], 3000);
    check("post_rst_ch0", w[1][0], 3000);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
